mdu_sequencer: RTL and testbench

- Multi-cycle RV32M unsigned multiply/divide controller.
- Computes MUL, DIVU and REMU by sequencing the shared 32-bit ALU for the add and subtract steps of each iteration, so no dedicated multiplier or divider is instantiated.
- Sits beside the ALU in the execute path. While busy it owns the ALU operand/op mux; the core stalls on busy and takes the result on done.

---
 rtl/mdu_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multi-cycle RV32M unsigned MUL / DIVU / REMU controller.
// It borrows the shared execute-stage ALU for the add/subtract step of each
// iteration, so no multiplier or divider array exists in this block.
// Optional feature macro: MDU_DIVZERO_FAST_EN. When defined, DIVU/REMU by zero
// completes in one cycle without touching the ALU.
//
// Handshake: start is sampled only while busy=0. The cycle start=1 is
// seen in IDLE, op/src_a/src_b are captured and busy rises on the next
// cycle. busy stays high through RUN and DONE. done is a single-cycle pulse
// in DONE, and result is valid from that cycle until it is overwritten by a
// later operation. Any start seen while busy=1 is dropped (no queuing).
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_res,
  output logic [1:0]      state_dbg
);

  localparam int            CW         = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] COUNT_INIT = CW'(ITERS - 1);
  localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Three working registers shared between the two algorithms:
  //   acc_rem    : MUL accumulator      / DIV partial remainder
  //   mcand_dvsr : MUL shifted mcand    / DIV divisor
  //   mplr_quo   : MUL shifted mplr     / DIV dividend shifting into quotient
  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] acc_rem_q, acc_rem_d;
  logic [XLEN-1:0] mcand_dvsr_q, mcand_dvsr_d;
  logic [XLEN-1:0] mplr_quo_q, mplr_quo_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] div_partial;
  logic            div_fits;
  logic            div_zero_fast;

  // Low 32 bits of the 33-bit shifted remainder {rem, quo[msb]}; the dropped
  // top bit (rem[msb]) forces a fit because the true value then exceeds 2^32.
  assign div_partial = {acc_rem_q[XLEN-2:0], mplr_quo_q[XLEN-1]};
  assign div_fits    = acc_rem_q[XLEN-1] | (div_partial >= mcand_dvsr_q);

`ifdef MDU_DIVZERO_FAST_EN
  assign div_zero_fast = op[1] & (src_b == '0);
`else
  assign div_zero_fast = 1'b0;
`endif

  // Next-state, datapath step and ALU operand mux.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    op_d         = op_q;
    acc_rem_d    = acc_rem_q;
    mcand_dvsr_d = mcand_dvsr_q;
    mplr_quo_d   = mplr_quo_q;
    result_d     = result_q;
    alu_op       = ALU_ADD;
    alu_a        = '0;
    alu_b        = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          count_d   = COUNT_INIT;
          acc_rem_d = '0;
          if (op[1]) begin
            mcand_dvsr_d = src_b;
            mplr_quo_d   = src_a;
          end else begin
            mcand_dvsr_d = src_a;
            mplr_quo_d   = src_b;
          end
          if (div_zero_fast) begin
            state_d  = S_DONE;
            result_d = op[0] ? src_a : '1;
          end else begin
            state_d = S_RUN;
          end
        end
      end

      S_RUN: begin
        count_d = count_q - COUNT_ONE;
        if (op_q[1]) begin
          // Restoring division step: trial subtract, keep it if it fits.
          alu_op     = ALU_SUB;
          alu_a      = div_partial;
          alu_b      = mcand_dvsr_q;
          acc_rem_d  = div_fits ? alu_res : div_partial;
          mplr_quo_d = {mplr_quo_q[XLEN-2:0], div_fits};
        end else begin
          // Shift-add multiply step; the reserved op rides this path too.
          alu_op       = ALU_ADD;
          alu_a        = acc_rem_q;
          alu_b        = mcand_dvsr_q;
          if (mplr_quo_q[0]) acc_rem_d = alu_res;
          mcand_dvsr_d = mcand_dvsr_q << 1;
          mplr_quo_d   = mplr_quo_q >> 1;
        end
        if (count_q == '0) begin
          state_d = S_DONE;
          case (op_q)
            OP_MUL:  result_d = acc_rem_d;
            OP_DIVU: result_d = mplr_quo_d;
            OP_REMU: result_d = acc_rem_d;
            default: result_d = '0;
          endcase
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      op_q         <= '0;
      acc_rem_q    <= '0;
      mcand_dvsr_q <= '0;
      mplr_quo_q   <= '0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      op_q         <= op_d;
      acc_rem_q    <= acc_rem_d;
      mcand_dvsr_q <= mcand_dvsr_d;
      mplr_quo_q   <= mplr_quo_d;
      result_q     <= result_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: directed plus randomized bench for mdu_sequencer.
// Provides a behavioural add/sub ALU on the alu_* ports and compares every
// completed operation against plain-arithmetic reference results.
module tb_mdu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  mdu_sequencer #(.XLEN(32), .ITERS(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res),
    .state_dbg (state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared execute ALU: 0000 add, 0001 sub.
  assign alu_res = (alu_op == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (o)
      2'b00:   return p[31:0];
      2'b01:   return 32'h0;
      2'b10:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] o, input logic [31:0] b);
`ifdef MDU_DIVZERO_FAST_EN
    if (o[1] && b == 32'h0) return 1;
`endif
    return 33;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: issue one operation from IDLE and check it through to completion.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    int          n;
    int          busy_n;
    int          bad_alu;
    int          lat;
    logic [31:0] exp;
    logic [3:0]  exp_alu;
    exp     = ref_model(o, a, b);
    lat     = exp_latency(o, b);
    exp_alu = o[1] ? 4'b0001 : 4'b0000;
    exp_q.push_back(exp);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    step();
    start = 1'b0;
    op    = 2'($urandom_range(0, 3));
    src_a = $urandom;
    src_b = $urandom;
    n       = 1;
    busy_n  = 0;
    bad_alu = 0;
    while (done !== 1'b1 && n < 200) begin
      if (busy === 1'b1) busy_n++;
      if (alu_op !== exp_alu) bad_alu++;
      step();
      n++;
    end
    if (busy === 1'b1) busy_n++;
    check({tag, "_latency"}, n, lat);
    check({tag, "_busy_cycles"}, busy_n, lat);
    check({tag, "_run_alu_op"}, bad_alu, 0);
    check({tag, "_result"}, result, exp_q.pop_front());
    step();
    check({tag, "_done_low"}, {31'b0, done}, 32'h0);
    check({tag, "_busy_low"}, {31'b0, busy}, 32'h0);
    check({tag, "_idle_alu"}, alu_a | alu_b | {28'b0, alu_op}, 32'h0);
    check({tag, "_held"}, result, exp);
  endtask

  // Directed sequence followed by randomized operations.
  initial begin
    int          n;
    int          n_done;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] e1;
    logic [31:0] e2;

    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    src_a = 32'h0;
    src_b = 32'h0;
    repeat (3) step();
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_alu", alu_a | alu_b | {28'b0, alu_op}, 32'h0);
    rst = 1'b0;
    step();
    check("idle_busy", {31'b0, busy}, 32'h0);

    run_op(2'b00, 32'd7, 32'd6, "mul_7x6");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ones");
    run_op(2'b10, 32'd100, 32'd7, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, "remu_100_7");
    run_op(2'b10, 32'hFFFF_FFFF, 32'd1, "divu_max_1");
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "remu_msb");
    run_op(2'b10, 32'h0000_1234, 32'h0, "divu_by0");
    run_op(2'b11, 32'h0000_1234, 32'h0, "remu_by0");
    run_op(2'b01, 32'd5, 32'd9, "reserved_op");
    run_op(2'b00, 32'h0001_0001, 32'h0001_0001, "mul_wrap");

    // start held high every cycle while busy must be ignored.
    e1 = ref_model(2'b00, 32'd7, 32'd6);
    exp_q.push_back(e1);
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'd7;
    src_b = 32'd6;
    step();
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      start = 1'b1;
      op    = 2'b10;
      src_a = $urandom;
      src_b = $urandom;
      step();
      n++;
    end
    check("ign_latency", n, 33);
    check("ign_result", result, exp_q.pop_front());
    e2 = ref_model(2'b11, 32'd100, 32'd7);
    exp_q.push_back(e2);
    op    = 2'b11;
    src_a = 32'd100;
    src_b = 32'd7;
    step();
    check("ign_first_idle", {31'b0, busy}, 32'h0);
    step();
    start = 1'b0;
    n = 2;
    while (done !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    check("ign_period", n, 34);
    check("ign_result2", result, exp_q.pop_front());
    step();

    // Reset in RUN cycle 10 aborts with no done pulse.
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'h0001_2345;
    src_b = 32'h0000_0777;
    step();
    start = 1'b0;
    repeat (9) step();
    check("rst_pre_busy", {31'b0, busy}, 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    check("rst_alu", alu_a | alu_b | {28'b0, alu_op}, 32'h0);
    n_done = 0;
    repeat (40) begin
      if (done === 1'b1) n_done++;
      step();
    end
    check("rst_no_done", n_done, 0);
    run_op(2'b00, 32'd3, 32'd5, "mul_after_rst");

    // Randomized operations, with occasional zero and small divisors.
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      else if ($urandom_range(0, 1) == 1) rb = $urandom;
      else rb = 32'($urandom_range(1, 255));
      run_op(ro, ra, rb, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
